image_scanner: RTL and testbench

Parametrised 2-D pixel address scanner and streaming front end for the image path. It walks an H_PIXELS × V_PIXELS frame in raster order, or optionally serpentine order, driving (x, y) to pixel storage. It captures the returned pixel word into a one-entry output register with valid/ready backpressure and flags end-of-line, end-of-frame and frame completion. It is a single-clock successor to the fixed 16×16 image controller, with no ripple-clocked counters.

---
 rtl/image_scanner.sv | 149 ++++++++++++++
 tb/tb_image_scanner.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/image_scanner.sv
// Pixel address scanner with a one-entry valid/ready output register and a frame-done pulse.
// Define IMAGE_SCANNER_SERPENTINE_EN for serpentine order (odd rows scan right-to-left).
module image_scanner #(
  parameter  int H_PIXELS = 16,
  parameter  int V_PIXELS = 16,
  parameter  int DATA_W   = 16,
  localparam int XW       = $clog2(H_PIXELS),
  localparam int YW       = $clog2(V_PIXELS)
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              clear,
  input  logic [DATA_W-1:0] pix_in,
  output logic [XW-1:0]     x,
  output logic [YW-1:0]     y,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_eol,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done
);

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_e;

  localparam logic [XW-1:0] XMAX = XW'(H_PIXELS - 1);
  localparam logic [YW-1:0] YMAX = YW'(V_PIXELS - 1);

  state_e state_q, state_d;

  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              eol_q, eol_d;
  logic              last_q, last_d;
  logic              done_q, done_d;

  logic adv, accept, rowEnd, lastRow, lastPixel;

  // The output register takes a new beat whenever it is empty or being emptied.
  assign accept    = valid_q & out_ready;
  assign adv       = (state_q == SCAN) & (~valid_q | out_ready);
  assign lastRow   = (y_q == YMAX);
`ifdef IMAGE_SCANNER_SERPENTINE_EN
  assign rowEnd    = y_q[0] ? (x_q == '0) : (x_q == XMAX);
`else
  assign rowEnd    = (x_q == XMAX);
`endif
  assign lastPixel = rowEnd & lastRow;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = SCAN;
        SCAN:    if (adv && lastPixel) state_d = DRAIN;
        DRAIN:   if (accept && last_q) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // Address returns to the origin whenever the scanner is (or is about to be) idle.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (state_d == IDLE) begin
      x_d = '0;
      y_d = '0;
    end else if (adv && !lastPixel) begin
`ifdef IMAGE_SCANNER_SERPENTINE_EN
      if (rowEnd)      y_d = y_q + 1'b1;
      else if (y_q[0]) x_d = x_q - 1'b1;
      else             x_d = x_q + 1'b1;
`else
      if (rowEnd) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
`endif
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    eol_d   = eol_q;
    last_d  = last_q;
    if (clear) begin
      valid_d = 1'b0;
      eol_d   = 1'b0;
      last_d  = 1'b0;
    end else if (adv) begin
      data_d  = pix_in;
      valid_d = 1'b1;
      eol_d   = rowEnd;
      last_d  = lastPixel;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  assign done_d = ~clear & (state_q == DRAIN) & accept & last_q;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      eol_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      eol_q   <= eol_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign data_out   = data_q;
  assign out_valid  = valid_q;
  assign out_eol    = eol_q;
  assign out_last   = last_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_image_scanner.sv
// Directed bench for image_scanner: a 16x16 instance and a 5x3 instance checked against a
// scan-order model; follows serpentine order when IMAGE_SCANNER_SERPENTINE_EN is defined.
module tb_image_scanner;

  logic        clk;
  logic        nrst;
  logic        start1, start2;
  logic        clear;
  logic        outReady;

  logic [3:0]  x1, y1;
  logic [15:0] pix1, data1;
  logic        valid1, eol1, last1, busy1, done1;

  logic [2:0]  x2;
  logic [1:0]  y2;
  logic [15:0] pix2, data2;
  logic        valid2, eol2, last2, busy2, done2;

  bit sel;
  int numChecks;
  int numFails;
  int cyc;
  int ex, ey, eol;

  int obsX, obsY, obsData, obsValid, obsEol, obsLast, obsBusy, obsDone;

  function automatic logic [15:0] pixFn(input int px, input int py);
    return 16'(py * 37 + px * 11 + 32'h1234);
  endfunction

  assign pix1 = pixFn(int'(x1), int'(y1));
  assign pix2 = pixFn(int'(x2), int'(y2));

  image_scanner #(.H_PIXELS(16), .V_PIXELS(16), .DATA_W(16)) dut1 (
    .clk(clk), .nrst(nrst), .start(start1), .clear(clear), .pix_in(pix1),
    .x(x1), .y(y1), .data_out(data1), .out_valid(valid1), .out_ready(outReady),
    .out_eol(eol1), .out_last(last1), .busy(busy1), .frame_done(done1)
  );

  image_scanner #(.H_PIXELS(5), .V_PIXELS(3), .DATA_W(16)) dut2 (
    .clk(clk), .nrst(nrst), .start(start2), .clear(clear), .pix_in(pix2),
    .x(x2), .y(y2), .data_out(data2), .out_valid(valid2), .out_ready(outReady),
    .out_eol(eol2), .out_last(last2), .busy(busy2), .frame_done(done2)
  );

  assign obsX     = sel ? int'(x2)     : int'(x1);
  assign obsY     = sel ? int'(y2)     : int'(y1);
  assign obsData  = sel ? int'(data2)  : int'(data1);
  assign obsValid = sel ? int'(valid2) : int'(valid1);
  assign obsEol   = sel ? int'(eol2)   : int'(eol1);
  assign obsLast  = sel ? int'(last2)  : int'(last1);
  assign obsBusy  = sel ? int'(busy2)  : int'(busy1);
  assign obsDone  = sel ? int'(done2)  : int'(done1);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    numChecks++;
    if (actual != expected) begin
      numFails++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic setStart(input bit v);
    if (sel) start2 = v;
    else     start1 = v;
  endtask

  // Independent model of scan order: beat k -> coordinate and end-of-line flag.
  task automatic expBeat(input int k, input int hp, output int bx, output int by, output int beol);
    int col;
    by   = k / hp;
    col  = k % hp;
    bx   = col;
`ifdef IMAGE_SCANNER_SERPENTINE_EN
    if (by % 2 == 1) bx = hp - 1 - col;
`endif
    beol = (col == hp - 1) ? 1 : 0;
  endtask

  // Starts a frame on the selected instance and consumes beats until the frame ends,
  // stopAt beats have been accepted, or the cycle budget runs out.
  task automatic applyStimulus(input bit randReady, input int stopAt, output int cyclesUsed);
    int hp, total, beat, cycles, bx, by, beol;
    bit stalled;
    int sData, sEol, sLast, sX, sY;
    hp      = sel ? 5 : 16;
    total   = sel ? 15 : 256;
    beat    = 0;
    cycles  = 0;
    stalled = 1'b0;
    sData = 0; sEol = 0; sLast = 0; sX = 0; sY = 0;
    setStart(1'b1);
    @(posedge clk); #1;
    setStart(1'b0);
    checkOutput("busyAfterStart", obsBusy, 1);
    checkOutput("originX", obsX, 0);
    checkOutput("originY", obsY, 0);
    checkOutput("noBeatYet", obsValid, 0);
    while (beat < total && beat != stopAt && cycles < 4000) begin
      outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      setStart(cycles == 20);
      @(negedge clk);
      if (obsValid != 0) begin
        if (stalled) begin
          checkOutput("stallData", obsData, sData);
          checkOutput("stallEol", obsEol, sEol);
          checkOutput("stallLast", obsLast, sLast);
          checkOutput("stallX", obsX, sX);
          checkOutput("stallY", obsY, sY);
        end
        if (outReady) begin
          expBeat(beat, hp, bx, by, beol);
          checkOutput("beatData", obsData, int'(pixFn(bx, by)));
          checkOutput("beatEol", obsEol, beol);
          checkOutput("beatLast", obsLast, (beat == total - 1) ? 1 : 0);
          if (beat == total - 1) setStart(1'b1);
          beat++;
          stalled = 1'b0;
        end else begin
          sData = obsData; sEol = obsEol; sLast = obsLast; sX = obsX; sY = obsY;
          stalled = 1'b1;
        end
      end
      @(posedge clk); #1;
      cycles++;
    end
    setStart(1'b0);
    cyclesUsed = cycles;
    if (beat != total && beat != stopAt) begin
      checkOutput("frameTimeout", beat, (stopAt >= 0) ? stopAt : total);
    end else if (beat == total) begin
      checkOutput("frameDone", obsDone, 1);
      checkOutput("busyAtDone", obsBusy, 0);
      checkOutput("validAtDone", obsValid, 0);
      @(posedge clk); #1;
      checkOutput("doneOneCycle", obsDone, 0);
      checkOutput("idleAfterDone", obsBusy, 0);
      checkOutput("idleX", obsX, 0);
      checkOutput("idleY", obsY, 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    numChecks = 0;
    numFails  = 0;
    sel       = 1'b0;
    nrst      = 1'b0;
    start1    = 1'b0;
    start2    = 1'b0;
    clear     = 1'b0;
    outReady  = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstX", obsX, 0);
    checkOutput("rstY", obsY, 0);
    checkOutput("rstData", obsData, 0);
    checkOutput("rstValid", obsValid, 0);
    checkOutput("rstEol", obsEol, 0);
    checkOutput("rstLast", obsLast, 0);
    checkOutput("rstBusy", obsBusy, 0);
    checkOutput("rstDone", obsDone, 0);
    nrst = 1'b1;
    @(posedge clk); #1;

    $display("[TB] 16x16 frame, out_ready held high");
    applyStimulus(1'b0, -1, cyc);
    checkOutput("consecutiveBeats", cyc, 257);

    $display("[TB] 16x16 frame, random out_ready");
    applyStimulus(1'b1, -1, cyc);

    $display("[TB] 5x3 frame");
    sel = 1'b1;
    applyStimulus(1'b0, -1, cyc);
    checkOutput("consecutiveBeats5x3", cyc, 16);
    sel = 1'b0;

    $display("[TB] clear with a pending beat 37");
    applyStimulus(1'b0, 37, cyc);
    outReady = 1'b0;
    @(negedge clk);
    expBeat(37, 16, ex, ey, eol);
    checkOutput("clearPreValid", obsValid, 1);
    checkOutput("clearPreData", obsData, int'(pixFn(ex, ey)));
    clear = 1'b1;
    start1 = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    start1 = 1'b0;
    checkOutput("clearBusy", obsBusy, 0);
    checkOutput("clearX", obsX, 0);
    checkOutput("clearY", obsY, 0);
    checkOutput("clearValid", obsValid, 0);
    checkOutput("clearEol", obsEol, 0);
    checkOutput("clearLast", obsLast, 0);
    checkOutput("clearDone", obsDone, 0);
    @(posedge clk); #1;
    checkOutput("clearNoDone", obsDone, 0);
    checkOutput("clearStaysIdle", obsBusy, 0);
    applyStimulus(1'b0, -1, cyc);
    checkOutput("reissueBeats", cyc, 257);

    $display("[TB] reset during DRAIN");
    applyStimulus(1'b0, 255, cyc);
    outReady = 1'b0;
    @(negedge clk);
    checkOutput("drainBusy", obsBusy, 1);
    checkOutput("drainValid", obsValid, 1);
    checkOutput("drainLast", obsLast, 1);
    #2;
    nrst = 1'b0;
    #1;
    checkOutput("asyncRstX", obsX, 0);
    checkOutput("asyncRstY", obsY, 0);
    checkOutput("asyncRstData", obsData, 0);
    checkOutput("asyncRstValid", obsValid, 0);
    checkOutput("asyncRstLast", obsLast, 0);
    checkOutput("asyncRstEol", obsEol, 0);
    checkOutput("asyncRstBusy", obsBusy, 0);
    checkOutput("asyncRstDone", obsDone, 0);
    @(posedge clk); #1;
    nrst = 1'b1;
    @(posedge clk); #1;
    checkOutput("postRstDone", obsDone, 0);
    checkOutput("postRstBusy", obsBusy, 0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
